// File: rtl/conv_5_acc_sat_if.sv
// Stream bundle for conv_5_acc_sat: product input stream and saturated pixel output stream.
// The block connects through the slave modport. The producer/consumer side connects through the master modport.
// Optional macro CONV_5_ACC_BIAS_EN adds a per-pixel bias lane driven alongside din.
interface conv_5_acc_sat_if #(
  parameter int DIN_WIDTH  = 24,
  parameter int DOUT_WIDTH = 16
);

  // input stream from the multiplier
  logic signed [DIN_WIDTH-1:0]  din;
  logic                         din_valid;
  logic                         din_ready;

  // output stream to the writer
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         dout_ready;
  logic                         dout_sat;

`ifdef CONV_5_ACC_BIAS_EN
  // per-pixel bias in output units, sampled with the first product of a window
  logic signed [DOUT_WIDTH-1:0] bias;

  modport master (
    output din, din_valid, bias, dout_ready,
    input  din_ready, dout, dout_valid, dout_sat
  );

  modport slave (
    input  din, din_valid, bias, dout_ready,
    output din_ready, dout, dout_valid, dout_sat
  );
`else
  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_sat
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_sat
  );
`endif

endinterface

// File: rtl/conv_5_acc_sat.sv
// Sums NUM_TAPS signed products per pixel, then rounds half-up, shifts right by SHIFT and saturates to DOUT_WIDTH.
// The result is valid on the second edge after the last product is accepted. At least NUM_TAPS+2 cycles are needed per pixel.
// din_ready is low while a result is finishing or held. The result is held unchanged until dout_ready. Optional macro: CONV_5_ACC_BIAS_EN.
module conv_5_acc_sat #(
  parameter int DIN_WIDTH  = 24,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int NUM_TAPS   = 25,
  parameter int SHIFT      = 7
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  conv_5_acc_sat_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  // half an output LSB, added before the shift; this is zero when SHIFT is 0
  localparam logic signed [ACC_WIDTH:0] RND =
    ((ACC_WIDTH + 1)'(1) << SHIFT) >> 1;

  // output range limits, widened to the rounding width for comparison
  localparam logic signed [ACC_WIDTH:0] SAT_HI =
    {{(ACC_WIDTH + 2 - DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_LO =
    {{(ACC_WIDTH + 2 - DOUT_WIDTH){1'b1}}, {(DOUT_WIDTH - 1){1'b0}}};
  localparam logic signed [DOUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DOUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ACC = 2'd0,
    FIN = 2'd1,
    OUT = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic                         din_ready;
  logic                         beat;

  logic [CNT_W-1:0]             cnt;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  din_ext;
  logic signed [ACC_WIDTH-1:0]  first_val;

  logic signed [ACC_WIDTH:0]    rnd_sum;
  logic signed [ACC_WIDTH:0]    shifted;
  logic signed [DOUT_WIDTH-1:0] sat_val;
  logic                         sat_flag;

  logic signed [DOUT_WIDTH-1:0] dout_q;
  logic                         dout_sat_q;
  logic                         dout_valid_q;

  assign din_ext = {{(ACC_WIDTH - DIN_WIDTH){bus.din[DIN_WIDTH-1]}}, bus.din};

`ifdef CONV_5_ACC_BIAS_EN
  logic signed [ACC_WIDTH-1:0]  bias_ext;

  // bias is scaled up by SHIFT so that it lands in output units after the final shift
  assign bias_ext  = {{(ACC_WIDTH - DOUT_WIDTH){bus.bias[DOUT_WIDTH-1]}}, bus.bias};
  assign first_val = din_ext + (bias_ext <<< SHIFT);
`else
  assign first_val = din_ext;
`endif

  // a product is taken only when din_ready is high, and din_ready depends on state alone
  assign beat = din_ready && bus.din_valid;

  // state register
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic and the input-side ready
  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    unique case (state)
      ACC: begin
        din_ready = 1'b1;
        if (bus.din_valid && (cnt == LAST_TAP)) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = OUT;
      end
      OUT: begin
        if (dout_valid_q && bus.dout_ready) begin
          state_nxt = ACC;
        end
      end
      default: begin
        state_nxt = ACC;
      end
    endcase
  end

  // accumulate the window: the first tap loads and later taps add, wrapping at ACC_WIDTH
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (beat) begin
      acc <= (cnt == '0) ? first_val : (acc + din_ext);
      cnt <= (cnt == LAST_TAP) ? '0 : (cnt + 1'b1);
    end
  end

  // round half toward +inf, then do an arithmetic shift, with one guard bit so the rounding add cannot wrap
  always_comb begin
    rnd_sum = {acc[ACC_WIDTH-1], acc} + RND;
    shifted = rnd_sum >>> SHIFT;
  end

  // clip to the signed output range and flag when clipping happened
  always_comb begin
    sat_val  = shifted[DOUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if (shifted > SAT_HI) begin
      sat_val  = OUT_MAX;
      sat_flag = 1'b1;
    end else if (shifted < SAT_LO) begin
      sat_val  = OUT_MIN;
      sat_flag = 1'b1;
    end
  end

  // capture the result in FIN and hold it until the consumer takes it
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      dout_q       <= '0;
      dout_sat_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      if (state == FIN) begin
        dout_q       <= sat_val;
        dout_sat_q   <= sat_flag;
        dout_valid_q <= 1'b1;
      end else if ((state == OUT) && bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_sat   = dout_sat_q;
  assign bus.dout_valid = dout_valid_q;

  // a held result must not change while the consumer stalls
  property p_hold_stable;
    @(posedge ap_clk) disable iff (!ap_rst_n)
      (dout_valid_q && !bus.dout_ready) |=> (dout_valid_q && $stable(dout_q) && $stable(dout_sat_q));
  endproperty
  a_hold_stable: assert property (p_hold_stable);

  // input and output never handshake-capable together
  a_no_overlap: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) !(din_ready && dout_valid_q));

endmodule

// File: doc/conv_5_acc_sat.md
Name: conv_5_acc_sat

Overview:
- Downstream consumer of the conv_5 16x8 signed multiplier.
- Accumulates NUM_TAPS signed 24-bit products (one 5x5 kernel window) into a wide accumulator, then rounds, right-shifts and saturates to a 16-bit output pixel.
- Valid/ready on both sides; sits between the multiplier and the conv_5 output writer.

Parameters:
- DIN_WIDTH, 24, signed product width from the multiplier.
- ACC_WIDTH, 32, accumulator width. Must be >= DIN_WIDTH + ceil(log2(NUM_TAPS)).
- DOUT_WIDTH, 16, signed output width.
- NUM_TAPS, 25, products per output pixel (2..256).
- SHIFT, 7, arithmetic right shift applied before saturation (0..ACC_WIDTH-2).

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  synchronous, active-low reset.
- din  in  DIN_WIDTH  signed product from the multiplier.
- din_valid  in  1  din is valid.
- din_ready  out  1  block accepts din this cycle.
- dout  out  DOUT_WIDTH  signed saturated result.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  consumer accepts dout.
- dout_sat  out  1  result was clipped; qualified by dout_valid.

Interface decision: one clock, ap_clk; reset ap_rst_n is synchronous and active-low.

Behaviour:
- Reset (ap_rst_n=0 at a rising edge):
  - state=ACC, tap counter=0, acc=0.
  - dout=0, dout_valid=0, dout_sat=0, din_ready=1 from the first cycle after reset.
  - Reset overrides everything, including mid-accumulation and while holding a result; any partial sum is discarded.
- States: ACC, FIN, OUT.
- ACC:
  - din_ready=1, dout_valid=0.
  - Beat accepted when din_valid=1 in ACC.
  - Accepted beat with cnt==0: acc <= sign_extend(din).
  - Accepted beat with cnt!=0: acc <= acc + sign_extend(din).
  - acc arithmetic wraps modulo 2^ACC_WIDTH. No overflow detection; parameter sizing guarantees none.
  - Each accepted beat: cnt <= cnt+1.
  - On the accepted beat with cnt==NUM_TAPS-1: cnt <= 0, go to FIN.
  - No beat accepted: acc and cnt hold.
- FIN (exactly one cycle):
  - din_ready=0.
  - r = acc + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in ACC_WIDTH+1 bits.
  - s = r >>> SHIFT (arithmetic, round-half-up toward +inf).
  - If s > 2^(DOUT_WIDTH-1)-1: dout <= max, dout_sat <= 1.
  - If s < -2^(DOUT_WIDTH-1): dout <= min, dout_sat <= 1.
  - Otherwise: dout <= s[DOUT_WIDTH-1:0], dout_sat <= 0.
  - dout_valid <= 1, go to OUT.
- OUT:
  - din_ready=0.
  - dout, dout_sat and dout_valid held stable until dout_valid & dout_ready.
  - On handshake: dout_valid <= 0, go to ACC; din_ready=1 the next cycle.
  - dout and dout_sat retain their last value after handshake; they are don't-care while dout_valid=0.
- Latency: last beat accepted at edge N → dout_valid=1 after edge N+1.
- Throughput: NUM_TAPS+2 cycles per pixel minimum. No input is accepted while in FIN or OUT.
- din_ready is a pure function of state and never depends on din_valid. dout_valid never depends on dout_ready.

Optional Feature:
- Macro: CONV_5_ACC_BIAS_EN.
- Defined:
  - Adds input port bias (DOUT_WIDTH, signed).
  - bias is sampled on the first accepted beat (cnt==0).
  - That beat sets acc <= sign_extend(din) + (sign_extend(bias) << SHIFT).
  - All other behaviour is unchanged.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
1. Hold ap_rst_n=0 for 3 edges, then release → dout=0, dout_valid=0, dout_sat=0, din_ready=1. Then apply 12 beats of din=1000, assert reset, then 25 beats of din=128 with dout_ready=1 → dout=25, dout_sat=0 (partial sum discarded).
2. 25 back-to-back beats of din=128, dout_ready=1 → acc=3200; dout=25, dout_sat=0; dout_valid=1 exactly 2 edges after last beat; din_ready=1 again the cycle after handshake.
3. 25 beats of din=-64 → acc=-1600; dout=-12 (0xFFF4), dout_sat=0.
4. 25 beats of din=8388607 → dout=32767, dout_sat=1. 25 beats of din=-8388608 → dout=-32768, dout_sat=1.
5. din_valid toggled 1/0 each cycle, with dout_ready=0 for 10 cycles after dout_valid → exactly 25 beats counted; dout stable and din_ready=0 throughout the stall; single handshake when dout_ready=1.
6. With CONV_5_ACC_BIAS_EN: bias=-10, 25 beats din=128 → dout=15. Without the macro, the same stimulus → dout=25.
